// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the round-robin memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RDWAIT
  } state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_picker #(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NREQ)) sum = sum - (IDX_W+1)'(NREQ);
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NREQ requesters,
// one transaction in flight: arbitrate, strobe, read-latency wait, data return.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ-1:0]             we,
  input  logic [NREQ-1:0][ADDR_W-1:0] addr,
  input  logic [NREQ-1:0][DATA_W-1:0] wdata,
  output logic [NREQ-1:0]             gnt,
  output logic [NREQ-1:0]             rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        busy,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_data_in,
  input  logic [DATA_W-1:0]           mem_data_out
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = 2;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic               we_q, we_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [NREQ-1:0]    rvalid_q, rvalid_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               busy_q, busy_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_data_in_q, mem_data_in_d;

  logic [NREQ-1:0]    pick_onehot;
  logic [IDX_W-1:0]   pick_idx;

  rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_picker (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    win_d         = win_q;
    we_d          = we_q;
    cnt_d         = cnt_q;
    gnt_d         = '0;
    rvalid_d      = '0;
    rdata_d       = rdata_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    unique case (state_q)
      IDLE: begin
        // Only the winner's fields are muxed out, so idle lanes never reach mem_*.
        if (req != '0) begin
          win_d         = pick_idx;
          we_d          = we[pick_idx];
          gnt_d         = pick_onehot;
          ptr_d         = (pick_idx == IDX_W'(NREQ-1)) ? '0 : pick_idx + IDX_W'(1);
          mem_write_d   = we[pick_idx];
          mem_read_d    = ~we[pick_idx];
          mem_addr_d    = addr[pick_idx];
          mem_data_in_d = wdata[pick_idx];
          state_d       = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d = RDWAIT;
          cnt_d   = CNT_W'(RD_LAT - 1);
        end
      end
      RDWAIT: begin
        if (cnt_q == '0) begin
          rdata_d         = mem_data_out;
          rvalid_d[win_q] = 1'b1;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      win_q         <= '0;
      we_q          <= 1'b0;
      cnt_q         <= '0;
      gnt_q         <= '0;
      rvalid_q      <= '0;
      rdata_q       <= '0;
      busy_q        <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      win_q         <= win_d;
      we_q          <= we_d;
      cnt_q         <= cnt_d;
      gnt_q         <= gnt_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      busy_q        <= busy_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end

  assign gnt         = gnt_q;
  assign rvalid      = rvalid_q;
  assign rdata       = rdata_q;
  assign busy        = busy_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter that shares one 32x8 single-port memory (read/write strobes, 5-bit addr, 8-bit data in/out) between NREQ test or DMA requesters.
- Sits between the requester interfaces and the memory.
- Sequences each transaction: arbitrate, one-cycle access strobe, read-latency wait, read-data return.
- Exactly one transaction is in flight at any time.

Parameters:
- NREQ, 2, number of requesters (2..8)
- ADDR_W, 5, memory address width
- DATA_W, 8, memory data width
- RD_LAT, 1, cycles from the read-strobe cycle to valid mem_data_out (1..4)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester request; held with its command until gnt
- we  in  NREQ  per-requester command: 1=write, 0=read
- addr  in  NREQ x ADDR_W  per-requester address (packed 2-D)
- wdata  in  NREQ x DATA_W  per-requester write data
- gnt  out  NREQ  one-hot, one-cycle pulse; command accepted
- rvalid  out  NREQ  one-hot, one-cycle pulse; rdata valid for that requester
- rdata  out  DATA_W  registered read data; holds its value between reads
- busy  out  1  high whenever state != IDLE
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_data_in  out  DATA_W  data to memory
- mem_data_out  in  DATA_W  data from memory

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- All outputs are registered.
- Reset values: gnt=0, rvalid=0, rdata=0, busy=0, mem_read=0, mem_write=0, mem_addr=0, mem_data_in=0, rr pointer=0, state=IDLE.
- States: IDLE, ACCESS, RDWAIT.
- IDLE, cycle T, when req!=0:
  - Winner w = first set bit of req, searching upward from ptr and wrapping.
  - At the edge ending T: latch we[w]/addr[w]/wdata[w]; gnt[w]<=1; ptr<=(w+1) mod NREQ; state<=ACCESS.
  - mem_write<=we[w]; mem_read<=~we[w]; mem_addr<=addr[w]; mem_data_in<=wdata[w].
- IDLE with req==0: hold state; all strobes stay 0.
- ACCESS, cycle T+1:
  - Strobes and gnt are high for exactly this cycle; they clear at the next edge.
  - Write: state<=IDLE. A write occupies 2 cycles; next arbitration happens in T+2.
  - Read: state<=RDWAIT; wait counter<=RD_LAT-1.
- RDWAIT:
  - Counter decrements each cycle.
  - In the cycle where the counter is 0 (cycle T+1+RD_LAT): sample mem_data_out into rdata, rvalid[w]<=1, state<=IDLE.
  - rvalid[w] and the new rdata are therefore visible in cycle T+2+RD_LAT.
  - During that same cycle the arbiter is in IDLE and may arbitrate.
- Requester rules:
  - A requester may change req/we/addr/wdata after the edge that ends its gnt cycle.
  - Dropping req before gnt withdraws the request without side effects.
  - A requester still asserting req after gnt is treated as a new request; the rr pointer guarantees others are served first.
- Fairness: with k requesters continuously requesting, each is granted exactly once in every k consecutive grants.
- Simultaneous requests: only the winner gets gnt; the others wait with no loss of their pending request.
- Pointer wrap: ptr=NREQ-1 followed by a grant moves ptr to 0.
- Reset mid-operation: the in-flight transaction is dropped at the reset edge.
  - A pending rvalid is never issued.
  - Strobes drop in the cycle after the rst edge.
  - The memory contents for an already-strobed write are not rolled back.
- No X propagation: unused requester inputs never reach the mem_* outputs.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, RDWAIT};
  - ADDR_W/DATA_W default constants;
  - a cmd struct {we, addr, wdata}.
- Sub-module rr_picker (combinational): inputs req vector and ptr; outputs one-hot winner and binary index.
- mem_arbiter holds the FSM, the command/latency registers and the output muxing.

Test Plan:
- Single write: req[0]=1, we[0]=1, addr=5'h0A, wdata=8'h5C at T -> gnt[0] and mem_write=1, mem_addr=0A, mem_data_in=5C in T+1; busy=0 in T+2; a later read of 0A returns 5C.
- Single read, RD_LAT=1: req[1] reads 0A at T -> gnt[1] and mem_read in T+1; rvalid[1]=1 and rdata=8'h5C in T+3; rvalid pulse is exactly 1 cycle.
- Contention: req=2'b11 at T with ptr=0 -> gnt[0] in T+1; gnt[1] on the next arbitration; with both requesters continuously requesting, grants alternate 0,1,0,1.
- Fairness, NREQ=4: req=4'b1011 held for 9 grants -> grant order 0,1,3,0,1,3,0,1,3; requester 2 is never granted.
- Reset mid-read, RD_LAT=3: assert rst in the first RDWAIT cycle -> no rvalid afterwards; all outputs 0 and busy=0 after the reset edge; a following write then completes normally.
- Withdraw: req[2] pulsed during another requester's ACCESS and dropped before arbitration -> gnt[2] never asserts; ptr is unaffected.
